// File: rtl/dual_edge_seq_pkg.sv
// Shared types for the dual-edge capture sequencer: edge modes, FSM states,
// command record layout and small edge-mode decode helpers.
package dual_edge_seq_pkg;

    localparam int unsigned CMD_DATA_W = 8;
    localparam int unsigned CMD_CNT_W  = 4;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_POS  = 2'd1,
        EDGE_NEG  = 2'd2,
        EDGE_BOTH = 2'd3
    } edge_mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [CMD_DATA_W-1:0] data;
        logic [CMD_DATA_W-1:0] step;
        logic [CMD_DATA_W-1:0] mask;
        edge_mode_t            edge_mode;
        logic [CMD_CNT_W-1:0]  beats;
    } cmd_t;

    // True when the mode drives the posedge capture enables
    function automatic logic pos_enabled(input edge_mode_t m);
        return (m == EDGE_POS) || (m == EDGE_BOTH);
    endfunction

    // True when the mode drives the negedge capture enables
    function automatic logic neg_enabled(input edge_mode_t m);
        return (m == EDGE_NEG) || (m == EDGE_BOTH);
    endfunction

endpackage

// File: rtl/dual_edge_seq_fifo.sv
// Synchronous command FIFO with occupancy count; push and pop in the same
// cycle are both honoured (count unchanged). Head entry is read combinationally.
module dual_edge_seq_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // State registers; reset empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dual_edge_seq.sv
// Command-driven beat sequencer feeding dual_edge_ff: queues latch commands
// and replays each as a burst of one beat per clock with accumulating data.
module dual_edge_seq
    import dual_edge_seq_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = CMD_DATA_W,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned           FIFO_DEPTH  = 4,
    parameter int unsigned           CNT_WIDTH   = CMD_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [DATA_WIDTH-1:0]         cmd_data,
    input  logic [DATA_WIDTH-1:0]         cmd_step,
    input  logic [DATA_WIDTH-1:0]         cmd_mask,
    input  logic [1:0]                    cmd_edge,
    input  logic [CNT_WIDTH-1:0]          cmd_beats,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [DATA_WIDTH-1:0]         pos_edge_latch_en,
    output logic [DATA_WIDTH-1:0]         neg_edge_latch_en,
    output logic                          busy,
    output logic                          cmd_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    // Same layout as cmd_t, but sized by this instance's parameters
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [DATA_WIDTH-1:0] step;
        logic [DATA_WIDTH-1:0] mask;
        edge_mode_t            edge_mode;
        logic [CNT_WIDTH-1:0]  beats;
    } entry_t;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    entry_t push_entry, head;
    logic   fifo_full, fifo_empty, fifo_pop;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] pos_q, pos_d;
    logic [DATA_WIDTH-1:0] neg_q, neg_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] step_q, step_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    edge_mode_t            mode_q, mode_d;
    logic [CNT_WIDTH-1:0]  remain_q, remain_d;

    assign push_entry = '{data:      cmd_data,
                          step:      cmd_step,
                          mask:      cmd_mask,
                          edge_mode: edge_mode_t'(cmd_edge),
                          beats:     cmd_beats};

    dual_edge_seq_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_level)
    );

    assign cmd_ready         = !fifo_full;
    assign busy              = (state_q == RUN) || !fifo_empty;
    assign data_in           = data_q;
    assign pos_edge_latch_en = pos_q;
    assign neg_edge_latch_en = neg_q;
    assign cmd_done          = done_q;

    // Beat generation: IDLE pops and emits beat 0, RUN accumulates data.
    // The last beat always returns to IDLE, which pops the next head on the
    // following edge, so back-to-back commands stay gap-free.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        pos_d    = '0;
        neg_d    = '0;
        done_d   = 1'b0;
        step_d   = step_q;
        mask_d   = mask_q;
        mode_d   = mode_q;
        remain_d = remain_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    step_d   = head.step;
                    mask_d   = head.mask;
                    mode_d   = head.edge_mode;
                    if (head.beats == '0) begin
                        // zero-beat command: one cycle, data held, no enables
                        done_d = 1'b1;
                    end else begin
                        data_d   = head.data;
                        pos_d    = pos_enabled(head.edge_mode) ? head.mask : '0;
                        neg_d    = neg_enabled(head.edge_mode) ? head.mask : '0;
                        remain_d = head.beats - ONE;
                        if (head.beats == ONE) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
            end
            RUN: begin
                data_d   = data_q + step_q;
                pos_d    = pos_enabled(mode_q) ? mask_q : '0;
                neg_d    = neg_enabled(mode_q) ? mask_q : '0;
                remain_d = remain_q - ONE;
                if (remain_q == ONE) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            data_q   <= RESET_VALUE;
            pos_q    <= '0;
            neg_q    <= '0;
            done_q   <= 1'b0;
            step_q   <= '0;
            mask_q   <= '0;
            mode_q   <= EDGE_NONE;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            pos_q    <= pos_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            step_q   <= step_d;
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            remain_q <= remain_d;
        end
    end

endmodule

// File: tb/tb_dual_edge_seq.sv
// Self-checking bench for dual_edge_seq: cycle-level reference model built
// from the command schedule, a table of back-to-back vectors, directed corner
// sequences, random traffic, and a behavioural downstream dual-edge FF.
module tb_dual_edge_seq;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_data;
    logic [DW-1:0] cmd_step;
    logic [DW-1:0] cmd_mask;
    logic [1:0]    cmd_edge;
    logic [3:0]    cmd_beats;
    logic [DW-1:0] data_in;
    logic [DW-1:0] pos_edge_latch_en;
    logic [DW-1:0] neg_edge_latch_en;
    logic          busy;
    logic          cmd_done;
    logic [2:0]    fifo_level;

    dual_edge_seq #(
        .DATA_WIDTH  (DW),
        .RESET_VALUE (8'h00),
        .FIFO_DEPTH  (DEPTH),
        .CNT_WIDTH   (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_data          (cmd_data),
        .cmd_step          (cmd_step),
        .cmd_mask          (cmd_mask),
        .cmd_edge          (cmd_edge),
        .cmd_beats         (cmd_beats),
        .data_in           (data_in),
        .pos_edge_latch_en (pos_edge_latch_en),
        .neg_edge_latch_en (neg_edge_latch_en),
        .busy              (busy),
        .cmd_done          (cmd_done),
        .fifo_level        (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural downstream dual-edge FF
    logic [DW-1:0] ff_q;
    always @(posedge clk or negedge clk or negedge rst_n) begin
        if (!rst_n)   ff_q <= '0;
        else if (clk) ff_q <= (ff_q & ~pos_edge_latch_en) | (data_in & pos_edge_latch_en);
        else          ff_q <= (ff_q & ~neg_edge_latch_en) | (data_in & neg_edge_latch_en);
    end

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [29:0] RST_VEC = {8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0};

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0]  data;
        logic [7:0]  step;
        logic [7:0]  mask;
        logic [1:0]  mode;
        int unsigned beats;
    } mcmd_t;

    mcmd_t       mq[$];
    mcmd_t       cur;
    int unsigned cur_i;
    bit          m_more;
    logic [7:0]  m_data, m_pos, m_neg;
    logic        m_done;

    function automatic void model_reset();
        mq.delete();
        m_more = 1'b0;
        m_data = 8'h00;
        m_pos  = 8'h00;
        m_neg  = 8'h00;
        m_done = 1'b0;
        cur_i  = 0;
    endfunction

    // beat i of the current command: data = base + i*step (mod 256)
    function automatic void emit(input int unsigned i);
        logic [31:0] v;
        v      = 32'(cur.data) + i * 32'(cur.step);
        m_data = v[7:0];
        m_pos  = cur.mode[0] ? cur.mask : 8'h00;
        m_neg  = cur.mode[1] ? cur.mask : 8'h00;
        m_done = (i == cur.beats - 1);
        m_more = !m_done;
    endfunction

    function automatic void model_edge();
        int unsigned lvl_pre;
        bit          acc;
        mcmd_t       c;
        if (!rst_n) begin
            model_reset();
            return;
        end
        lvl_pre = mq.size();
        acc     = cmd_valid && (lvl_pre < DEPTH);
        m_pos   = 8'h00;
        m_neg   = 8'h00;
        m_done  = 1'b0;
        if (m_more) begin
            cur_i++;
            emit(cur_i);
        end else if (lvl_pre > 0) begin
            cur   = mq.pop_front();
            cur_i = 0;
            if (cur.beats == 0) begin
                m_done = 1'b1;
                m_more = 1'b0;
            end else begin
                emit(0);
            end
        end else begin
            m_more = 1'b0;
        end
        if (acc) begin
            c.data  = cmd_data;
            c.step  = cmd_step;
            c.mask  = cmd_mask;
            c.mode  = cmd_edge;
            c.beats = cmd_beats;
            mq.push_back(c);
        end
    endfunction

    function automatic logic [29:0] exp_vec();
        return {m_data, m_pos, m_neg, m_done, (m_more || mq.size() != 0),
                (mq.size() < DEPTH), 3'(mq.size())};
    endfunction

    function automatic logic [29:0] dut_vec();
        return {data_in, pos_edge_latch_en, neg_edge_latch_en, cmd_done, busy,
                cmd_ready, fifo_level};
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input string nm);
        @(posedge clk);
        model_edge();
        #1;
        chk(nm, 64'(dut_vec()), 64'(exp_vec()));
    endtask

    task automatic set_cmd(input logic v, input logic [7:0] d, input logic [7:0] s,
                           input logic [7:0] m, input logic [1:0] e, input logic [3:0] b);
        cmd_valid = v;
        cmd_data  = d;
        cmd_step  = s;
        cmd_mask  = m;
        cmd_edge  = e;
        cmd_beats = b;
    endtask

    task automatic drain();
        cmd_valid = 1'b0;
        for (int i = 0; i < 200 && (m_more || mq.size() != 0); i++) tick("drain");
        chk("drain_idle", 64'(busy), 64'(0));
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        #100;
        chk("reset", 64'(dut_vec()), 64'(RST_VEC));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- back-to-back vector table ----------------
    typedef struct {
        logic       valid;
        logic [7:0] data, step, mask;
        logic [1:0] mode;
        logic [3:0] beats;
        logic [7:0] e_data, e_pos, e_neg;
        logic       e_done;
    } row_t;

    row_t tbl[8];
    int   done_cnt;

    initial begin
        tbl[0] = '{1'b1, 8'h10, 8'h01, 8'hF0, 2'd1, 4'd2, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 8'h20, 8'h00, 8'hFF, 2'd3, 4'd1, 8'h10, 8'hF0, 8'h00, 1'b0};
        tbl[2] = '{1'b1, 8'h30, 8'h02, 8'hFF, 2'd0, 4'd2, 8'h11, 8'hF0, 8'h00, 1'b1};
        tbl[3] = '{1'b1, 8'h40, 8'h05, 8'hFF, 2'd1, 4'd0, 8'h20, 8'hFF, 8'hFF, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 4'd0, 8'h30, 8'h00, 8'h00, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 4'd0, 8'h32, 8'h00, 8'h00, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 4'd0, 8'h32, 8'h00, 8'h00, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 4'd0, 8'h32, 8'h00, 8'h00, 1'b0};

        set_cmd(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 4'd0);
        model_reset();
        do_reset();

        // POS single beat plus downstream capture timing
        set_cmd(1'b1, 8'hA5, 8'h00, 8'hFF, 2'd1, 4'd1);
        tick("pos_accept");
        cmd_valid = 1'b0;
        tick("pos_beat");
        chk("pos_beat_outputs", 64'({data_in, pos_edge_latch_en, neg_edge_latch_en, cmd_done}),
            64'({8'hA5, 8'hFF, 8'h00, 1'b1}));
        @(negedge clk); #1;
        chk("pos_ff_at_negedge", 64'(ff_q), 64'(8'h00));
        tick("pos_idle");
        chk("pos_ff_at_posedge", 64'(ff_q), 64'(8'hA5));

        // BOTH single beat: captured at negedge, identical at next posedge
        drain();
        set_cmd(1'b1, 8'h3C, 8'h00, 8'hFF, 2'd3, 4'd1);
        tick("both_accept");
        cmd_valid = 1'b0;
        tick("both_beat");
        @(negedge clk); #1;
        chk("both_ff_at_negedge", 64'(ff_q), 64'(8'h3C));
        tick("both_idle");
        chk("both_ff_at_posedge", 64'(ff_q), 64'(8'h3C));

        // NEG burst with data wrap
        drain();
        set_cmd(1'b1, 8'hFE, 8'h01, 8'h0F, 2'd2, 4'd3);
        tick("neg_accept");
        cmd_valid = 1'b0;
        tick("neg_b0");
        chk("neg_beat0", 64'({data_in, pos_edge_latch_en, neg_edge_latch_en, cmd_done}),
            64'({8'hFE, 8'h00, 8'h0F, 1'b0}));
        tick("neg_b1");
        chk("neg_beat1", 64'({data_in, pos_edge_latch_en, neg_edge_latch_en, cmd_done}),
            64'({8'hFF, 8'h00, 8'h0F, 1'b0}));
        tick("neg_b2");
        chk("neg_beat2", 64'({data_in, pos_edge_latch_en, neg_edge_latch_en, cmd_done}),
            64'({8'h00, 8'h00, 8'h0F, 1'b1}));
        tick("neg_idle");
        chk("neg_after", 64'({data_in, pos_edge_latch_en, neg_edge_latch_en, cmd_done}),
            64'({8'h00, 8'h00, 8'h00, 1'b0}));

        // Back-to-back table from a fresh reset
        drain();
        do_reset();
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            set_cmd(tbl[i].valid, tbl[i].data, tbl[i].step, tbl[i].mask, tbl[i].mode, tbl[i].beats);
            tick("b2b_model");
            chk($sformatf("b2b_row%0d", i),
                64'({data_in, pos_edge_latch_en, neg_edge_latch_en, cmd_done}),
                64'({tbl[i].e_data, tbl[i].e_pos, tbl[i].e_neg, tbl[i].e_done}));
            if (cmd_done) done_cnt++;
        end
        chk("b2b_done_count", 64'(done_cnt), 64'(4));

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            set_cmd(($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom), 8'($urandom),
                    2'($urandom_range(0, 3)), 4'($urandom_range(0, 5)));
            tick("rand");
        end
        drain();

        // Reset in the middle of a long burst with a second command queued
        set_cmd(1'b1, 8'h05, 8'h03, 8'hFF, 2'd1, 4'd10);
        tick("mid_accept");
        set_cmd(1'b1, 8'h77, 8'h01, 8'hFF, 2'd3, 4'd2);
        tick("mid_queue");
        cmd_valid = 1'b0;
        repeat (4) tick("mid_burst");
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_async", 64'(dut_vec()), 64'(RST_VEC));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) tick("post_reset");
        chk("post_reset_level", 64'(fifo_level), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dual_edge_seq.md
# dual_edge_seq

Command-driven sequencer sitting directly upstream of `dual_edge_ff`. Accepts latch commands over a valid/ready interface, buffers them in a small FIFO, and replays each as a burst of beats on `data_in` / `pos_edge_latch_en` / `neg_edge_latch_en`, one beat per clock. Beat data steps arithmetically within a burst. Lets the datapath schedule posedge-, negedge- or both-edge captures without cycle-level handling.

## Interface
- `DATA_WIDTH`, 8, width of data and per-bit enable masks
- `RESET_VALUE`, 0, reset value of `data_in`; matches the downstream FF's reset value
- `FIFO_DEPTH`, 4, command FIFO entries; power of two, ≥2
- `CNT_WIDTH`, 4, width of `cmd_beats`
- `clk` in 1: single clock; all logic on posedge
- `rst_n` in 1: asynchronous, active-low reset
- `cmd_valid` in 1: command offered
- `cmd_ready` out 1: FIFO can accept; transfer when valid && ready at posedge
- `cmd_data` in DATA_WIDTH: beat-0 data
- `cmd_step` in DATA_WIDTH: per-beat data increment
- `cmd_mask` in DATA_WIDTH: per-bit enable mask
- `cmd_edge` in 2: 0 NONE, 1 POS, 2 NEG, 3 BOTH
- `cmd_beats` in CNT_WIDTH: beats in burst; 0 allowed
- `data_in` out DATA_WIDTH: to FF `data_in`
- `pos_edge_latch_en` out DATA_WIDTH: to FF
- `neg_edge_latch_en` out DATA_WIDTH: to FF
- `busy` out 1: FSM in RUN or FIFO non-empty
- `cmd_done` out 1: one-cycle pulse on a command's final output cycle
- `fifo_level` out $clog2(FIFO_DEPTH)+1: occupied entries

## Operation
- Reset (async assert, sync release): `data_in`=RESET_VALUE, both enables 0, `cmd_done`=0, FIFO empty, `cmd_ready`=1, `busy`=0, FSM IDLE.
- `cmd_ready` = !full, from registered count; no combinational path from pop.
- FSM IDLE: if FIFO non-empty, pop head and emit beat 0 in the same edge; go to RUN if beats >1, otherwise stay in IDLE with `cmd_done` set.
- FSM RUN: emit beat i each cycle. On the last beat, pop the next head if FIFO is non-empty and emit its beat 0 on the next cycle, with no bubble; otherwise go to IDLE.
- Beat i: `data_in` = cmd_data + i*cmd_step mod 2^DATA_WIDTH, computed by accumulation; wrap-around is silent.
- Beat enables:
  - POS: `pos_edge_latch_en`=mask, `neg_edge_latch_en`=0
  - NEG: neg=mask, pos=0
  - BOTH: both=mask
  - NONE: both 0, data still driven (spacer)
- `cmd_beats`=0: command occupies one output cycle with enables 0, `data_in` held, `cmd_done` pulsed.
- Cycles with no beat: enables 0, `data_in` holds last value.
- Simultaneous push and pop: allowed when not full; level unchanged.
- Reset mid-burst: outputs return to reset values immediately; queued commands are discarded.

## Timing
- All outputs are registered.
- Command accepted at edge k into an idle, empty block: beat 0 appears after edge k+1; beat i after edge k+1+i.
- `cmd_done` is high in the same cycle as the final beat.
- Downstream capture of a beat driven after edge n:
  - NEG: at the following negedge (half cycle)
  - POS: at edge n+1
  - BOTH: at both; `data_out` is identical both times
- Throughput: one beat per cycle sustained across commands.

## Structure
- Package `dual_edge_seq_pkg`:
  - `edge_mode_t` enum (NONE/POS/NEG/BOTH)
  - `state_t` enum (IDLE/RUN)
  - packed `cmd_t` struct {data, step, mask, edge, beats}, parameterised via localparam widths
- Sub-module `dual_edge_seq_fifo`: synchronous FIFO of `cmd_t`, with count, full/empty and simultaneous push/pop.
- Top level: FSM, beat counter, data accumulator, output registers.

## Test plan
- Reset: hold `rst_n`=0 for 100 ns → `data_in`=0, enables 0, `cmd_ready`=1, `busy`=0, `fifo_level`=0.
- POS single beat: data=0xA5, mask=0xFF, beats=1, accepted at edge k → after edge k+1, `data_in`=0xA5, pos=0xFF, neg=0, `cmd_done`=1. Downstream FF `data_out`=0xA5 after edge k+2 and unchanged at the preceding negedge.
- NEG burst with wrap: data=0xFE, step=1, beats=3, mask=0x0F → `data_in` sequence 0xFE, 0xFF, 0x00, neg=0x0F each cycle; `cmd_done` only on 0x00.
- Back-to-back: four commands pushed consecutively (POS, BOTH, NONE, beats=0), each beats≤2 → `cmd_ready` low only while `fifo_level`=4. Outputs are gap-free. Beats=0 command gives one cycle of zero enables. `cmd_done` count = 4.
- BOTH: data=0x3C, beats=1 → FF `data_out`=0x3C at the negedge, still 0x3C at the next posedge.
- Reset mid-burst: beats=10, `rst_n` dropped after beat 4 → enables 0 and `data_in`=0 immediately (async). After release, `fifo_level`=0 and no further beats.
